// File: rtl/hilo_mac_unit_if.sv
// Execute-stage to HI/LO unit operation bundle.
// Master drives operations; slave reports busy and committed HI/LO.
interface hilo_mac_unit_if #(
   parameter int W = 32
);
   logic           flush;
   logic           op_valid;
   logic [2:0]     op;
   logic [W-1:0]   src_a;
   logic [W-1:0]   src_b;
   logic [2*W-1:0] wdata;
   logic           busy;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;

   modport master (
      output flush, op_valid, op, src_a, src_b, wdata,
      input  busy, hi, lo
   );

   modport slave (
      input  flush, op_valid, op, src_a, src_b, wdata,
      output busy, hi, lo
   );
endinterface

// File: rtl/hilo_mac_unit.sv
// HI/LO register pair with partial writes and a two-stage
// multiply-accumulate/subtract pipeline.
module hilo_mac_unit #(
   parameter int W = 32
) (
   input logic              clk,
   input logic              rst,
   hilo_mac_unit_if.slave   bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;

   localparam logic [2:0] WR_HILO = 3'd1;
   localparam logic [2:0] WR_HI   = 3'd2;
   localparam logic [2:0] WR_LO   = 3'd3;

   logic [1:0]     state;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           sgn_q;
   logic           sub_q;
   logic [2*W-1:0] prod;
   logic [W-1:0]   hi_q;
   logic [W-1:0]   lo_q;

   logic           accept;
   logic [2*W-1:0] ext_a;
   logic [2*W-1:0] ext_b;
   logic [2*W-1:0] hilo;
   logic [2*W-1:0] acc;

   assign accept = (state == IDLE) && bus.op_valid &&
                   !bus.flush && (bus.op != 3'd0);

   // Extension choice makes the low 2W bits of the product exact
   // for both signed and unsigned operands.
   assign ext_a = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
   assign ext_b = sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};

   assign hilo = {hi_q, lo_q};
   assign acc  = sub_q ? (hilo - prod) : (hilo + prod);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         sub_q <= 1'b0;
         prod  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else if (bus.flush) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  unique case (bus.op)
                     WR_HILO: {hi_q, lo_q} <= bus.wdata;
                     WR_HI:   hi_q <= bus.src_a;
                     WR_LO:   lo_q <= bus.src_a;
                     default: begin
                        a_q   <= bus.src_a;
                        b_q   <= bus.src_b;
                        sgn_q <= ~bus.op[0];
                        sub_q <= bus.op[1];
                        state <= MUL;
                     end
                  endcase
               end
            end
            MUL: begin
               prod  <= ext_a * ext_b;
               state <= ACC;
            end
            ACC: begin
               {hi_q, lo_q} <= acc;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Scenario bench for hilo_mac_unit with an expected-value queue
// filled at stimulus time and drained at commit time.
module tb_hilo_mac_unit;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [63:0] exp_q[$];
   logic [63:0] m;
   logic [63:0] e;
   logic [63:0] got;

   hilo_mac_unit_if #(.W(32)) bus ();

   hilo_mac_unit #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign got = {bus.hi, bus.lo};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] wd);
      bus.op_valid = 1'b1;
      bus.op       = o;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.wdata    = wd;
   endtask

   task automatic quiet();
      bus.op_valid = 1'b0;
      bus.op       = 3'd0;
   endtask

   function automatic logic [63:0] mac_model(input logic [63:0] acc,
      input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      logic [63:0]        p;
      sp = $signed(a) * $signed(b);
      up = {32'h0, a} * {32'h0, b};
      p  = o[0] ? up : sp;
      return o[1] ? acc - p : acc + p;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_cmp++;
      if (got !== 64'h0) begin
         n_err++;
         $display("FAIL reset_hilo got=%h exp=0", got);
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy got=%b exp=0", bus.busy);
      end
      m = 64'h0;
   endtask

   task automatic test_wr_hilo();
      drive(3'd1, 32'h0, 32'h0, 64'h12345678_9ABCDEF0);
      m = 64'h12345678_9ABCDEF0;
      exp_q.push_back(m);
      step();
      quiet();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL wr_hilo got=%h exp=%h", got, e);
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL wr_hilo_busy got=%b exp=0", bus.busy);
      end
   endtask

   task automatic test_partial();
      drive(3'd2, 32'hFFFFFFFF, 32'h0, 64'h0);
      exp_q.push_back(64'hFFFFFFFF_9ABCDEF0);
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL wr_hi got=%h exp=%h", got, e);
      end
      drive(3'd3, 32'h0, 32'h0, 64'h0);
      exp_q.push_back(64'hFFFFFFFF_00000000);
      step();
      quiet();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL wr_lo got=%h exp=%h", got, e);
      end
      m = 64'hFFFFFFFF_00000000;
   endtask

   task automatic test_mac();
      drive(3'd1, 32'h0, 32'h0, 64'h0);
      step();
      drive(3'd4, 32'hFFFFFFFE, 32'd3, 64'h0);
      exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
      step();
      quiet();
      n_cmp++;
      if (bus.busy !== 1'b1 || got !== 64'h0) begin
         n_err++;
         $display("FAIL madd_t0 busy=%b hilo=%h exp busy=1 hilo=0",
                  bus.busy, got);
      end
      step();
      n_cmp++;
      if (bus.busy !== 1'b1 || got !== 64'h0) begin
         n_err++;
         $display("FAIL madd_t1 busy=%b hilo=%h exp busy=1 hilo=0",
                  bus.busy, got);
      end
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.busy !== 1'b0 || got !== e) begin
         n_err++;
         $display("FAIL madd busy=%b got=%h exp busy=0 %h",
                  bus.busy, got, e);
      end
      // (FFFFFFFF*FFFFFFFF) + FFFFFFFF_FFFFFFFA, mod 2^64
      drive(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0);
      exp_q.push_back(64'hFFFFFFFD_FFFFFFFB);
      step();
      quiet();
      step();
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL maddu got=%h exp=%h", got, e);
      end
      drive(3'd1, 32'h0, 32'h0, 64'h0);
      step();
      drive(3'd7, 32'd1, 32'd1, 64'h0);
      exp_q.push_back(64'hFFFFFFFF_FFFFFFFF);
      step();
      quiet();
      step();
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL msubu_wrap got=%h exp=%h", got, e);
      end
      drive(3'd6, 32'd1, 32'hFFFFFFFF, 64'h0);
      exp_q.push_back(64'h0);
      step();
      quiet();
      step();
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL msub got=%h exp=%h", got, e);
      end
      m = 64'h0;
   endtask

   task automatic test_flush();
      drive(3'd4, 32'd5, 32'd7, 64'h0);
      exp_q.push_back(m);
      step();
      quiet();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_mul_busy got=%b exp=0", bus.busy);
      end
      step();
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL flush_mul_hilo got=%h exp=%h", got, e);
      end
      drive(3'd4, 32'd5, 32'd7, 64'h0);
      exp_q.push_back(m);
      step();
      quiet();
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_acc_busy got=%b exp=0", bus.busy);
      end
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL flush_acc_hilo got=%h exp=%h", got, e);
      end
      drive(3'd1, 32'h0, 32'h0, 64'hDEADBEEF_CAFEF00D);
      bus.flush = 1'b1;
      exp_q.push_back(m);
      step();
      bus.flush = 1'b0;
      quiet();
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle got=%h busy=%b exp=%h busy=0",
                  got, bus.busy, e);
      end
   endtask

   task automatic test_busy_ignore();
      drive(3'd4, 32'd5, 32'd7, 64'h0);
      m = 64'd35;
      exp_q.push_back(m);
      step();
      drive(3'd1, 32'h0, 32'h0, 64'hDEADBEEF_CAFEF00D);
      step();
      step();
      quiet();
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_ignore got=%h busy=%b exp=%h busy=0",
                  got, bus.busy, e);
      end
   endtask

   task automatic test_rst_acc();
      drive(3'd5, 32'd100, 32'd100, 64'h0);
      exp_q.push_back(64'h0);
      step();
      quiet();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_acc got=%h busy=%b exp=%h busy=0",
                  got, bus.busy, e);
      end
      step();
      step();
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL rst_acc_late got=%h exp=%h", got, e);
      end
      m = 64'h0;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] wd;
      for (int i = 0; i < 10; i++) begin
         o  = 3'($urandom_range(1, 3));
         a  = $urandom;
         wd = {$urandom, $urandom};
         drive(o, a, 32'h0, wd);
         if (o == 3'd1)      m = wd;
         else if (o == 3'd2) m = {a, m[31:0]};
         else                m = {m[63:32], a};
         exp_q.push_back(m);
         step();
         e = exp_q.pop_front();
         n_cmp++;
         if (got !== e || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_wr[%0d] got=%h busy=%b exp=%h",
                     i, got, bus.busy, e);
         end
      end
      for (int i = 0; i < 8; i++) begin
         o = 3'($urandom_range(4, 7));
         a = $urandom;
         b = $urandom;
         drive(o, a, b, 64'h0);
         m = mac_model(m, o, a, b);
         exp_q.push_back(m);
         step();
         quiet();
         step();
         step();
         e = exp_q.pop_front();
         n_cmp++;
         if (got !== e || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_mac[%0d] op=%0d got=%h exp=%h",
                     i, o, got, e);
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.flush    = 1'b0;
      bus.op_valid = 1'b0;
      bus.op       = 3'd0;
      bus.src_a    = '0;
      bus.src_b    = '0;
      bus.wdata    = '0;
      test_reset();
      test_wr_hilo();
      test_partial();
      test_mac();
      test_flush();
      test_busy_ignore();
      test_rst_acc();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
